hls_ap_master: RTL and testbench

HLS_AP_MASTER -- requirements
Module: hls_ap_master

---
 rtl/hls_ap_master.sv | 161 ++++++++++++++++
 tb/tb_hls_ap_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hls_ap_master.sv
// hls_ap_master
//   Sequences one ap_ctrl_hs invocation of an HLS core for each accepted
//   command. It measures the latency from the first ap_start_o cycle to
//   ap_done_i and returns the core result, or aborts after TIMEOUT_CYCLES.
//
// Ports
//   clk_i, rstb_i            : clock and asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : command handshake (ready only when idle and core idle)
//   ap_start_o               : start to the core, held until ap_ready_i
//   ap_ready_i, ap_done_i,
//   ap_idle_i, ap_return_i   : core status and return value
//   res_valid_o/res_ready_i  : result handshake
//   res_data_o               : captured ap_return_i (0 on timeout)
//   res_cycles_o             : measured latency (TIMEOUT_CYCLES on timeout)
//   res_timeout_o            : result was produced by the timeout
//   err_spurious_o           : sticky, ap_done_i seen when not expected
//   busy_o                   : any state other than IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command while the core reports idle
// START | ap_start_o high, waiting for ap_ready_i
// RUN   | core accepted start, waiting for ap_done_i
// RESP  | result presented, waiting for res_ready_i
module hls_ap_master #(
  parameter int          CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  output logic             ap_start_o,
  input  logic             ap_ready_i,
  input  logic             ap_done_i,
  input  logic             ap_idle_i,
  input  logic [31:0]      ap_return_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [CNT_W-1:0] res_cycles_o,
  output logic             res_timeout_o,
  output logic             err_spurious_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      r_res_data;
  logic [CNT_W-1:0] r_res_cycles;
  logic             r_res_timeout;
  logic             r_err_spurious;

  logic w_accept;
  logic w_active;
  logic w_done_ok;
  logic w_timeout;
  logic w_spurious;

  assign w_active  = (r_state == S_START) || (r_state == S_RUN);
  assign w_accept  = (r_state == S_IDLE) && cmd_valid_i && ap_idle_i;

  // A done in START only counts when the core accepts start in the same cycle.
  assign w_done_ok = ap_done_i &&
                     (((r_state == S_START) && ap_ready_i) || (r_state == S_RUN));

  // Done on the last allowed cycle takes priority over the abort.
  assign w_timeout = w_active && (r_cnt == L_TO_LAST) && !w_done_ok;

  assign w_spurious = ap_done_i &&
                      ((r_state == S_IDLE) || (r_state == S_RESP) ||
                       ((r_state == S_START) && !ap_ready_i));

  assign w_cnt_inc = (r_cnt == L_CNT_MAX) ? r_cnt : (r_cnt + L_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_done_ok || w_timeout) w_state_nxt = S_RESP;
        else if (ap_ready_i)        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_done_ok || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (res_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      r_res_data    <= '0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
    end else if (w_done_ok) begin
      r_res_data    <= ap_return_i;
      r_res_cycles  <= w_cnt_inc;
      r_res_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_res_data    <= '0;
      r_res_cycles  <= L_TO_VAL;
      r_res_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      r_err_spurious <= 1'b0;
    end else if (w_spurious) begin
      r_err_spurious <= 1'b1;
    end
  end

  assign cmd_ready_o    = (r_state == S_IDLE) && ap_idle_i;
  assign ap_start_o     = (r_state == S_START);
  assign res_valid_o    = (r_state == S_RESP);
  assign busy_o         = (r_state != S_IDLE);
  assign res_data_o     = r_res_data;
  assign res_cycles_o   = r_res_cycles;
  assign res_timeout_o  = r_res_timeout;
  assign err_spurious_o = r_err_spurious;

endmodule

// File: tb/tb_hls_ap_master.sv
module tb_hls_ap_master;

  localparam int CNT_W = 16;
  localparam int T     = 100;

  logic             clk;
  logic             rstb;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic [31:0]      ap_return;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [CNT_W-1:0] res_cycles;
  logic             res_timeout;
  logic             err_spurious;
  logic             busy;

  int  checks   = 0;
  int  failures = 0;
  bit  exp_err  = 1'b0;

  hls_ap_master #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk),
    .rstb_i         (rstb),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .ap_start_o     (ap_start),
    .ap_ready_i     (ap_ready),
    .ap_done_i      (ap_done),
    .ap_idle_i      (ap_idle),
    .ap_return_i    (ap_return),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_cycles_o   (res_cycles),
    .res_timeout_o  (res_timeout),
    .err_spurious_o (err_spurious),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"},   ap_start,     0);
    chk({tag, "_rvalid"},  res_valid,    0);
    chk({tag, "_rdata"},   res_data,     0);
    chk({tag, "_rcycles"}, res_cycles,   0);
    chk({tag, "_rto"},     res_timeout,  0);
    chk({tag, "_err"},     err_spurious, 0);
    chk({tag, "_busy"},    busy,         0);
  endtask

  // One invocation driven by a core model: ready pulses r cycles after the
  // first start cycle, done d cycles after ready (never_done suppresses it).
  // Expectations come from the done cycle index alone.
  task automatic run_txn(input int r, input int d, input bit never_done,
                         input int spur_k, input int hold, input bit spur_resp,
                         input logic [31:0] ret);
    int k, sc, rc, done_k, exp_sc, exp_rc;
    bit captured;
    logic [31:0]      exp_data;
    logic [CNT_W-1:0] exp_cyc;
    bit exp_to;
    ap_idle   = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    ap_idle   = 1'b0;
    done_k = never_done ? (1 << 30) : (r + d);
    k = 0; sc = 0; rc = 0;
    while (!res_valid && k < 300) begin
      if (ap_start)  sc++;
      else if (busy) rc++;
      ap_ready  = (k == r);
      ap_done   = (k == done_k) || (spur_k >= 0 && k == spur_k && spur_k < r);
      ap_return = (k == done_k) ? ret : $urandom;
      @(negedge clk);
      k++;
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (!res_valid) chk("resp_reached", 0, 1);

    captured = (done_k <= T - 1);
    exp_data = captured ? ret : 32'h0;
    exp_cyc  = captured ? CNT_W'(done_k + 1) : CNT_W'(T);
    exp_to   = !captured;
    exp_sc   = (r <= T - 1) ? r + 1 : T;
    exp_rc   = (r > T - 1) ? 0 : (captured ? d : T - 1 - r);
    if (spur_k >= 0 && spur_k < r) exp_err = 1'b1;

    chk("res_valid",    res_valid,    1);
    chk("res_data",     res_data,     exp_data);
    chk("res_cycles",   res_cycles,   exp_cyc);
    chk("res_timeout",  res_timeout,  exp_to);
    chk("start_low",    ap_start,     0);
    chk("start_cycles", sc,           exp_sc);
    chk("run_cycles",   rc,           exp_rc);
    chk("err_after",    err_spurious, exp_err);

    cmd_valid = 1'b1;
    ap_idle   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      ap_done   = spur_resp && (i == hold / 2);
      ap_return = $urandom;
      @(negedge clk);
      chk("hold_valid",  res_valid,  1);
      chk("hold_cready", cmd_ready,  0);
      chk("hold_data",   res_data,   exp_data);
      chk("hold_cycles", res_cycles, exp_cyc);
      chk("hold_to",     res_timeout, exp_to);
    end
    ap_done = 1'b0;
    if (spur_resp) exp_err = 1'b1;
    chk("err_hold", err_spurious, exp_err);

    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_valid",  res_valid,  0);
    chk("idle_busy",   busy,       0);
    chk("idle_data",   res_data,   exp_data);
    chk("idle_cycles", res_cycles, exp_cyc);
  endtask

  initial begin
    rstb = 1'b0; cmd_valid = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    ap_idle = 1'b0; ap_return = '0; res_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rstb = 1'b1;

    // Core not idle: command must wait.
    cmd_valid = 1'b1;
    ap_idle   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("noidle_cready", cmd_ready, 0);
      chk("noidle_start",  ap_start,  0);
      chk("noidle_busy",   busy,      0);
    end

    run_txn(1, 40, 0, -1, 2, 0, 32'h0000_00A5);
    run_txn(0, 0, 0, -1, 1, 0, 32'h1234_5678);
    run_txn(1, 0, 1, -1, 1, 0, 32'hDEAD_BEEF);

    for (int n = 0; n < 10; n++) begin
      int r, d;
      r = ($urandom_range(3) == 0) ? int'($urandom_range(110, 90)) : int'($urandom_range(5, 0));
      d = ($urandom_range(3) == 0) ? int'($urandom_range(130, 95)) : int'($urandom_range(60, 0));
      run_txn(r, d, 0, -1, int'($urandom_range(4, 0)), 0, $urandom);
    end

    // Result held 20 cycles with a stray done in RESP.
    run_txn(2, 7, 0, -1, 20, 1, 32'hCAFE_0001);

    // Reset mid-RUN.
    ap_idle = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; ap_idle = 1'b0; ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_run_busy",  busy,     1);
    chk("mid_run_start", ap_start, 0);
    #2 rstb = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_cready", cmd_ready, 0);
    @(negedge clk);
    rstb = 1'b1;
    exp_err = 1'b0;
    run_txn(2, 10, 0, -1, 1, 0, 32'h0BAD_F00D);

    // Done while START is still waiting for ready is ignored but flagged.
    run_txn(3, 5, 0, 1, 2, 0, 32'h5555_AAAA);

    // Done in IDLE after a fresh reset.
    rstb = 1'b0;
    #1;
    @(negedge clk);
    rstb = 1'b1;
    exp_err = 1'b0;
    chk("idle_err_clear", err_spurious, 0);
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    chk("idle_err_set",  err_spurious, 1);
    chk("idle_err_busy", busy,         0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
